// File: rtl/axi4_lite_read_master_if.sv
// rtl/axi4_lite_read_master_if.sv - core request/response port and AXI4-Lite AR/R channels
interface axi4_lite_read_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();

    // Core-side request port
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;

    // Core-side response port
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_err;

    // AXI4-Lite read address channel
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_VALID;
    logic              AR_READY;

    // AXI4-Lite read data channel
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_VALID;
    logic              R_READY;

    modport master (
        input  req_valid, req_addr, resp_ready,
        input  AR_READY, R_DATA, R_RESP, R_VALID,
        output req_ready, resp_valid, resp_data, resp_err,
        output AR_ADDR, AR_VALID, R_READY
    );

    modport slave (
        output req_valid, req_addr, resp_ready,
        output AR_READY, R_DATA, R_RESP, R_VALID,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  AR_ADDR, AR_VALID, R_READY
    );

endinterface

// File: rtl/axi4_lite_read_master.sv
// rtl/axi4_lite_read_master.sv - single-outstanding AXI4-Lite read master with watchdog
module axi4_lite_read_master #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   CLK,
    input  logic                   RST,
    axi4_lite_read_master_if.master bus,
    output logic                   timeout_flag
);

    // Watchdog counter only needs to reach TIMEOUT_CYCLES-1; it saturates there,
    // so an AR handshake on the last allowed cycle still leaves the R phase guarded.
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t             state;
    logic               req_ready_q;
    logic               ar_valid_q;
    logic [ADDR_W-1:0]  ar_addr_q;
    logic               r_ready_q;
    logic               resp_valid_q;
    logic [DATA_W-1:0]  resp_data_q;
    logic [1:0]         resp_err_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   wd_cnt;

    logic ar_hs;
    logic r_hs;
    logic wd_active;
    logic wd_expire;

    assign ar_hs     = (state == S_ADDR) && ar_valid_q && bus.AR_READY;
    assign r_hs      = (state == S_DATA) && r_ready_q && bus.R_VALID;
    assign wd_active = (state == S_ADDR) || (state == S_DATA);
    assign wd_expire = WD_EN && wd_active && (wd_cnt == CNT_LAST);

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b1;
            ar_valid_q   <= 1'b0;
            ar_addr_q    <= '0;
            r_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 2'b00;
            timeout_q    <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            if (wd_active && (wd_cnt != CNT_LAST)) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        ar_addr_q   <= bus.req_addr;
                        ar_valid_q  <= 1'b1;
                        req_ready_q <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (ar_hs) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= S_DATA;
                    end else if (wd_expire) begin
                        ar_valid_q   <= 1'b0;
                        r_ready_q    <= 1'b0;
                        resp_data_q  <= '0;
                        resp_err_q   <= RESP_TIMEOUT;
                        timeout_q    <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end
                end

                S_DATA: begin
                    if (r_hs) begin
                        resp_data_q  <= bus.R_DATA;
                        resp_err_q   <= bus.R_RESP;
                        r_ready_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end else if (wd_expire) begin
                        ar_valid_q   <= 1'b0;
                        r_ready_q    <= 1'b0;
                        resp_data_q  <= '0;
                        resp_err_q   <= RESP_TIMEOUT;
                        timeout_q    <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end
                end

                S_RESP: begin
                    // A request offered in this cycle is not taken: req_ready rises next cycle
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.AR_VALID   = ar_valid_q;
    assign bus.AR_ADDR    = ar_addr_q;
    assign bus.R_READY    = r_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign timeout_flag   = timeout_q;

endmodule

// File: doc/axi4_lite_read_master.md
Name: axi4_lite_read_master

Overview:
- Master side of the AXI4-Lite read path; sits directly upstream of the AXI4-Lite read slave and drives its AR and R channels.
- Accepts single-word read requests from the core (IFU/LSU) over a valid/ready request port.
- Performs exactly one AR + R transaction per request and returns data plus response code on a valid/ready response port.
- One outstanding transaction at a time; an optional watchdog aborts hung transactions.

Parameters:
- ADDR_W, 64, width of request address and AR_ADDR.
- DATA_W, 64, width of R_DATA and resp_data.
- TIMEOUT_CYCLES, 256, cycles allowed from AR_VALID assertion to R beat acceptance; 0 disables the watchdog.

Ports:
- CLK  input  1  clock, all logic on posedge
- RST  input  1  synchronous active-high reset
- req_valid  input  1  core read request valid
- req_ready  output  1  master can accept a request
- req_addr  input  ADDR_W  read address, sampled on req_valid && req_ready
- resp_valid  output  1  response to core valid
- resp_ready  input  1  core accepts response
- resp_data  output  DATA_W  returned read data
- resp_err  output  2  AXI response code; 2'b11 = watchdog timeout
- AR_ADDR  output  ADDR_W  read address channel address
- AR_VALID  output  1  read address valid
- AR_READY  input  1  slave accepts address
- R_DATA  input  DATA_W  read data
- R_RESP  input  2  read response
- R_VALID  input  1  read data valid
- R_READY  output  1  master accepts read data
- timeout_flag  output  1  sticky; set on any watchdog abort, cleared only by RST

Behaviour:
- Reset (sync, RST=1 at posedge): state=IDLE; req_ready=1; AR_VALID=0; R_READY=0; resp_valid=0; AR_ADDR=0; resp_data=0; resp_err=2'b00; timeout_flag=0; watchdog counter=0. Reset mid-transaction aborts it unconditionally, with no response to the core.
- All outputs are registered. req_ready=1 only in IDLE (decoded from registered state).
- IDLE: on req_valid && req_ready, latch req_addr into AR_ADDR and set AR_VALID=1 next cycle -> ADDR. Otherwise stay.
- ADDR: AR_VALID held high and AR_ADDR held stable until AR_READY=1 is sampled.
  - At that edge: AR_VALID<=0, R_READY<=1 -> DATA.
  - An AR_READY pulse while AR_VALID=0 is ignored.
- DATA: R_READY held high.
  - On R_VALID && R_READY: resp_data<=R_DATA, resp_err<=R_RESP, R_READY<=0, resp_valid<=1 -> RESP.
  - An R_VALID seen in ADDR (before AR handshake) is not accepted, because R_READY=0 there.
- RESP: resp_valid, resp_data and resp_err held stable until resp_ready=1 is sampled; then resp_valid<=0 -> IDLE.
  - A request presented in the same cycle is not accepted; req_ready rises the cycle after.
- Minimum latency, with a slave that is ready immediately: request accept at edge 0; AR_VALID high after edge 0; AR_READY seen at edge 1; R beat at edge 2; resp_valid high after edge 2.
  - Throughput is at most one transaction per 4 cycles.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entering ADDR and increments every cycle in ADDR or DATA.
  - When count == TIMEOUT_CYCLES-1 and no AR/R handshake completes that cycle: AR_VALID<=0, R_READY<=0, resp_data<=0, resp_err<=2'b11, timeout_flag<=1, resp_valid<=1 -> RESP.
  - If a handshake and the timeout coincide, the handshake wins.
  - A late R beat after an abort is a system fault and is not tracked.
- Non-OKAY R_RESP (01/10/11) is passed through unmodified; the master does not retry.
- AR_ADDR holds its last value in all states after capture; it is not cleared on IDLE.

Test Plan:
- Basic read: req_addr=64'h8000_0010, slave AR_READY 1 cycle after AR_VALID, R_VALID with R_DATA=64'hDEAD_BEEF_0123_4567 and R_RESP=00 one cycle later, resp_ready=1 -> resp_valid for 1 cycle, resp_data=64'hDEAD_BEEF_0123_4567, resp_err=00, req_ready back to 1 the next cycle.
- AR backpressure: AR_READY held 0 for 5 cycles -> AR_VALID stays 1 and AR_ADDR stays 64'h8000_0010 for all 5 cycles; R_READY=0 throughout; DATA entered only after AR_READY=1.
- Response backpressure plus error: R_RESP=2'b10, R_DATA=64'h1, resp_ready low for 3 cycles -> resp_valid, resp_data=1 and resp_err=10 stable for 4 cycles; req_ready=0 until the cycle after acceptance.
- Timeout: TIMEOUT_CYCLES=8, slave never asserts AR_READY -> AR_VALID drops after 8 cycles in ADDR; resp_valid=1, resp_err=11, resp_data=0, timeout_flag=1 and stays 1 through later good reads.
- Reset mid-DATA: assert RST for 1 cycle while R_READY=1 -> next cycle R_READY=0, AR_VALID=0, resp_valid=0, req_ready=1; a new read afterwards completes normally.
- Back-to-back: req_valid held high with addresses 0x100, 0x108, 0x110 and a zero-wait slave -> three AR handshakes in address order, responses returned in order, 4-cycle spacing between request accepts.
